// File: rtl/conv2d_window_agen.sv
// KxK sliding-window read-address generator for 2-D convolution over a row-major image.
// Issues taps column-major per window, tracks memory latency and emits one write per window.
module conv2d_window_agen #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12,
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              d_valid,
  output logic              tap_first,
  output logic              tap_last,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              busy,
  output logic              done
);

  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int DW    = $clog2(RD_LAT + 1);

  if (K < 1 || STRIDE < 1 || RD_LAT < 1 || IMG_W < K || IMG_H < K) begin : g_bad_geometry
    $error("conv2d_window_agen: illegal geometry parameters");
  end
  if ((64'(IMG_W) * 64'(IMG_H)) > (64'd1 << ADDR_W)) begin : g_bad_addr_w
    $error("conv2d_window_agen: IMG_W*IMG_H does not fit in ADDR_W");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              v;
    logic              f;
    logic              l;
    logic [ADDR_W-1:0] idx;
  } stage_t;

  state_t            state_reg, state_next;
  logic [KW-1:0]     kr_reg, kr_next, kc_reg, kc_next;
  logic [XW-1:0]     ox_reg, ox_next;
  logic [YW-1:0]     oy_reg, oy_next;
  logic [DW-1:0]     drain_reg, drain_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              rd_en_reg, rd_en_next;
  logic              first_reg, first_next;
  logic              last_reg, last_next;
  stage_t            pipe_reg [RD_LAT];
  stage_t            pipe_tail;

  logic              issue;
  logic              kr_end, kc_end, ox_end, oy_end, frame_end;
  logic [ADDR_W-1:0] cur_row, cur_col, cur_addr, cur_idx;

  assign kr_end    = (kr_reg == KW'(K - 1));
  assign kc_end    = (kc_reg == KW'(K - 1));
  assign ox_end    = (ox_reg == XW'(OUT_W - 1));
  assign oy_end    = (oy_reg == YW'(OUT_H - 1));
  assign frame_end = kr_end && kc_end && ox_end && oy_end;

  // Tap address of the counters' current position, all arithmetic in ADDR_W bits.
  assign cur_row  = ADDR_W'(oy_reg) * ADDR_W'(STRIDE) + ADDR_W'(kr_reg);
  assign cur_col  = ADDR_W'(ox_reg) * ADDR_W'(STRIDE) + ADDR_W'(kc_reg);
  assign cur_addr = cur_row * ADDR_W'(IMG_W) + cur_col;
  assign cur_idx  = ADDR_W'(oy_reg) * ADDR_W'(OUT_W) + ADDR_W'(ox_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      kr_reg      <= '0;
      kc_reg      <= '0;
      ox_reg      <= '0;
      oy_reg      <= '0;
      drain_reg   <= '0;
      rd_addr_reg <= '0;
      idx_reg     <= '0;
      rd_en_reg   <= 1'b0;
      first_reg   <= 1'b0;
      last_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      kr_reg      <= kr_next;
      kc_reg      <= kc_next;
      ox_reg      <= ox_next;
      oy_reg      <= oy_next;
      drain_reg   <= drain_next;
      rd_addr_reg <= rd_addr_next;
      idx_reg     <= idx_next;
      rd_en_reg   <= rd_en_next;
      first_reg   <= first_next;
      last_reg    <= last_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    kr_next      = kr_reg;
    kc_next      = kc_reg;
    ox_next      = ox_reg;
    oy_next      = oy_reg;
    drain_next   = drain_reg;
    rd_addr_next = rd_addr_reg;
    idx_next     = idx_reg;
    rd_en_next   = 1'b0;
    first_next   = first_reg;
    last_next    = last_reg;
    issue        = 1'b0;

    case (state_reg)
      IDLE, DONE: issue = start;
      SCAN:       issue = !stall;
      DRAIN: begin
        if (drain_reg == DW'(RD_LAT)) state_next = DONE;
        else                          drain_next = drain_reg + 1'b1;
      end
      default:    state_next = IDLE;
    endcase

    // Counters always wrap back to zero after the last tap, so a new frame starts at tap 0.
    if (issue) begin
      rd_en_next   = 1'b1;
      rd_addr_next = cur_addr;
      first_next   = (kr_reg == '0) && (kc_reg == '0);
      last_next    = kr_end && kc_end;
      idx_next     = cur_idx;
      state_next   = frame_end ? DRAIN : SCAN;
      drain_next   = '0;
      if (!kr_end) begin
        kr_next = kr_reg + 1'b1;
      end else begin
        kr_next = '0;
        if (!kc_end) begin
          kc_next = kc_reg + 1'b1;
        end else begin
          kc_next = '0;
          if (!ox_end) begin
            ox_next = ox_reg + 1'b1;
          end else begin
            ox_next = '0;
            oy_next = oy_end ? '0 : oy_reg + 1'b1;
          end
        end
      end
    end
  end

  // Marker pipe mirrors the memory latency and shifts every cycle, so stalls become bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[0] <= '{v: rd_en_reg, f: first_reg, l: last_reg, idx: idx_reg};
      for (int i = 1; i < RD_LAT; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign pipe_tail = pipe_reg[RD_LAT-1];
  assign rd_addr   = rd_addr_reg;
  assign rd_en     = rd_en_reg;
  assign d_out     = d_in;
  assign d_valid   = pipe_tail.v;
  assign tap_first = pipe_tail.v & pipe_tail.f;
  assign tap_last  = pipe_tail.v & pipe_tail.l;
  assign wr_en     = pipe_tail.v & pipe_tail.l;
  assign wr_addr   = pipe_tail.idx;
  assign busy      = (state_reg == SCAN) || (state_reg == DRAIN);
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_conv2d_window_agen.sv
// Bench for conv2d_window_agen: two instances (default, and stride 2 with read latency 3)
// checked cycle by cycle against a tap list built from the window geometry.
module tb_conv2d_window_agen;

  localparam int AW = 17;
  localparam int DWD = 12;

  int p_w [2]   = '{5, 5};
  int p_h [2]   = '{5, 5};
  int p_k [2]   = '{3, 3};
  int p_s [2]   = '{1, 2};
  int p_lat [2] = '{1, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic start_v = 1'b0;
  logic stall_v = 1'b0;
  logic [DWD-1:0] d_in = '0;

  logic start0, start1, stall0, stall1;
  logic [AW-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [DWD-1:0] d_out0, d_out1;
  logic rd_en0, rd_en1, d_valid0, d_valid1, tap_first0, tap_first1, tap_last0, tap_last1;
  logic wr_en0, wr_en1, busy0, busy1, done0, done1;

  logic [AW-1:0] rd_addr_s, wr_addr_s;
  logic [DWD-1:0] d_out_s;
  logic rd_en_s, d_valid_s, tap_first_s, tap_last_s, wr_en_s, busy_s, done_s;

  assign start0 = start_v & ~sel;
  assign start1 = start_v & sel;
  assign stall0 = stall_v & ~sel;
  assign stall1 = stall_v & sel;

  assign rd_addr_s   = sel ? rd_addr1 : rd_addr0;
  assign wr_addr_s   = sel ? wr_addr1 : wr_addr0;
  assign d_out_s     = sel ? d_out1 : d_out0;
  assign rd_en_s     = sel ? rd_en1 : rd_en0;
  assign d_valid_s   = sel ? d_valid1 : d_valid0;
  assign tap_first_s = sel ? tap_first1 : tap_first0;
  assign tap_last_s  = sel ? tap_last1 : tap_last0;
  assign wr_en_s     = sel ? wr_en1 : wr_en0;
  assign busy_s      = sel ? busy1 : busy0;
  assign done_s      = sel ? done1 : done0;

  conv2d_window_agen #(.ADDR_W(AW), .DATA_W(DWD), .IMG_W(5), .IMG_H(5), .K(3),
                       .STRIDE(1), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .stall(stall0),
    .rd_addr(rd_addr0), .rd_en(rd_en0), .d_in(d_in), .d_out(d_out0),
    .d_valid(d_valid0), .tap_first(tap_first0), .tap_last(tap_last0),
    .wr_addr(wr_addr0), .wr_en(wr_en0), .busy(busy0), .done(done0));

  conv2d_window_agen #(.ADDR_W(AW), .DATA_W(DWD), .IMG_W(5), .IMG_H(5), .K(3),
                       .STRIDE(2), .RD_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .stall(stall1),
    .rd_addr(rd_addr1), .rd_en(rd_en1), .d_in(d_in), .d_out(d_out1),
    .d_valid(d_valid1), .tap_first(tap_first1), .tap_last(tap_last1),
    .wr_addr(wr_addr1), .wr_en(wr_en1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    bit first;
    bit last;
    int idx;
  } tap_t;
  tap_t taps[$];

  int obs [9];
  int obs_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference tap sequence straight from the window geometry.
  task automatic build_taps(input int d);
    int ow, oh;
    tap_t t;
    ow = (p_w[d] - p_k[d]) / p_s[d] + 1;
    oh = (p_h[d] - p_k[d]) / p_s[d] + 1;
    taps.delete();
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int kc = 0; kc < p_k[d]; kc++)
          for (int kr = 0; kr < p_k[d]; kr++) begin
            t.addr  = (oy * p_s[d] + kr) * p_w[d] + ox * p_s[d] + kc;
            t.first = (kr == 0) && (kc == 0);
            t.last  = (kr == p_k[d] - 1) && (kc == p_k[d] - 1);
            t.idx   = oy * ow + ox;
            taps.push_back(t);
          end
  endtask

  // mode 0: no stall, 1: 3-cycle stall after 4 taps, 2: random stall and spurious start.
  task automatic run_frame(input int d, input int mode, output int done_cyc, output int nwr);
    int n_taps, lat, issued, outp, n, last_rd, scnt;
    bit exp_rd, exp_dv, exp_done, s;
    int exp_a;
    bit hist[$];
    sel = d[0];
    lat = p_lat[d];
    build_taps(d);
    n_taps = taps.size();
    obs_cnt = 0;
    @(negedge clk);
    start_v = 1'b1;
    stall_v = 1'($urandom);
    d_in = DWD'($urandom);
    exp_rd = 1'b1;
    exp_a = taps[0].addr;
    issued = 1;
    last_rd = 1;
    outp = 0;
    n = 1;
    scnt = 0;
    nwr = 0;
    done_cyc = -1;
    while (n < 3000) begin
      @(negedge clk);
      chk("rd_en", rd_en_s, exp_rd);
      if (exp_rd || issued < n_taps) chk("rd_addr", rd_addr_s, exp_a);
      chk("d_out", d_out_s, d_in);
      if (rd_en_s && obs_cnt < 9) begin
        obs[obs_cnt] = rd_addr_s;
        obs_cnt++;
      end
      hist.push_back(exp_rd);
      exp_dv = (hist.size() > lat) ? hist[hist.size() - 1 - lat] : 1'b0;
      chk("d_valid", d_valid_s, exp_dv);
      if (wr_en_s) nwr++;
      if (exp_dv) begin
        if (outp < n_taps) begin
          chk("tap_first", tap_first_s, taps[outp].first);
          chk("tap_last", tap_last_s, taps[outp].last);
          chk("wr_en", wr_en_s, taps[outp].last);
          if (taps[outp].last) chk("wr_addr", wr_addr_s, taps[outp].idx);
        end else begin
          chk("extra_tap", d_valid_s, 0);
        end
        outp++;
      end else begin
        chk("wr_en_idle", wr_en_s, 0);
        chk("tap_first_idle", tap_first_s, 0);
      end
      exp_done = (issued == n_taps) && (n > last_rd + lat);
      chk("done", done_s, exp_done);
      chk("busy", busy_s, !exp_done);
      if (exp_done) begin
        done_cyc = n;
        break;
      end
      start_v = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      case (mode)
        0: s = 1'b0;
        1: begin
          s = (issued >= 4) && (scnt < 3);
          if (s) scnt++;
        end
        default: s = ($urandom_range(0, 3) == 0);
      endcase
      stall_v = s;
      d_in = DWD'($urandom);
      if (issued < n_taps && !s) begin
        exp_rd = 1'b1;
        exp_a = taps[issued].addr;
        issued++;
        last_rd = n + 1;
      end else begin
        exp_rd = 1'b0;
      end
      n++;
    end
    if (done_cyc < 0) chk("frame_timeout_done", done_s, 1);
    start_v = 1'b0;
    stall_v = 1'b0;
  endtask

  typedef struct {
    int dut;
    int mode;
    int exp_done;
    int exp_wr;
  } vec_t;

  initial begin
    vec_t vecs [7];
    int ref9 [9] = '{0, 5, 10, 1, 6, 11, 2, 7, 12};
    int dc, nw;

    vecs[0] = '{dut: 0, mode: 0, exp_done: 83, exp_wr: 9};
    vecs[1] = '{dut: 0, mode: 0, exp_done: 83, exp_wr: 9};
    vecs[2] = '{dut: 0, mode: 1, exp_done: 86, exp_wr: 9};
    vecs[3] = '{dut: 1, mode: 0, exp_done: 40, exp_wr: 4};
    vecs[4] = '{dut: 1, mode: 1, exp_done: 43, exp_wr: 4};
    vecs[5] = '{dut: 0, mode: 2, exp_done: -1, exp_wr: 9};
    vecs[6] = '{dut: 1, mode: 2, exp_done: -1, exp_wr: 4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      chk("rst_rd_addr", rd_addr_s, 0);
      chk("rst_rd_en", rd_en_s, 0);
      chk("rst_d_valid", d_valid_s, 0);
      chk("rst_wr_en", wr_en_s, 0);
      chk("rst_wr_addr", wr_addr_s, 0);
      chk("rst_busy", busy_s, 0);
      chk("rst_done", done_s, 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].dut, vecs[i].mode, dc, nw);
      $display("frame %0d: dut=%0d mode=%0d done_cycle=%0d writes=%0d", i, vecs[i].dut,
               vecs[i].mode, dc, nw);
      if (vecs[i].exp_done >= 0) chk("done_cycle", dc, vecs[i].exp_done);
      chk("write_count", nw, vecs[i].exp_wr);
      if (i == 0)
        for (int j = 0; j < 9; j++) chk("first_window_addr", obs[j], ref9[j]);
      repeat (2) @(negedge clk);
      chk("done_held", done_s, 1);
    end

    // Reset in the middle of a frame aborts it without any write.
    sel = 1'b0;
    @(negedge clk);
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    repeat (39) @(negedge clk);
    chk("mid_busy", busy_s, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rd_en", rd_en_s, 0);
    chk("mid_rst_rd_addr", rd_addr_s, 0);
    chk("mid_rst_d_valid", d_valid_s, 0);
    chk("mid_rst_tap_first", tap_first_s, 0);
    chk("mid_rst_tap_last", tap_last_s, 0);
    chk("mid_rst_wr_en", wr_en_s, 0);
    chk("mid_rst_wr_addr", wr_addr_s, 0);
    chk("mid_rst_busy", busy_s, 0);
    chk("mid_rst_done", done_s, 0);
    $display("mid-frame reset applied");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_wr_en", wr_en_s, 0);
      chk("post_rst_busy", busy_s, 0);
    end

    run_frame(0, 0, dc, nw);
    $display("frame after reset: done_cycle=%0d writes=%0d", dc, nw);
    chk("post_rst_done_cycle", dc, 83);
    chk("post_rst_write_count", nw, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
